// File: rtl/addr8u_tr_voter.sv
// Time-redundant wrapper around an external 8-bit adder: runs the sum over two
// passes (second one optionally swapped), adds a third on mismatch and votes.
module addr8u_tr_voter #(
    parameter int CNT_W   = 16,
    parameter int SETTLE  = 0,
    parameter bit SWAP_P2 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    input  logic [8:0]       add_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_sum,
    output logic             out_err,
    output logic             out_fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    typedef enum logic [2:0] {IDLE, P1, P2, P3, DONE} state_t;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t     state;
    logic [7:0] op_a, op_b;
    logic [8:0] r1, r2;
    logic [3:0] settle_cnt;
    logic       pass_end;
    logic [8:0] vote_sum;
    logic       vote_err, vote_fail;

    assign in_ready = (state == IDLE);
    assign pass_end = (settle_cnt == SETTLE_LAST);

    // The third result is voted straight off add_o on the edge it is captured,
    // so the decision does not cost an extra cycle.
    always_comb begin
        vote_sum  = r1;
        vote_err  = 1'b0;
        vote_fail = 1'b0;
        if (add_o == r1) begin
            vote_err = 1'b1;
        end else if (add_o == r2) begin
            vote_sum = r2;
            vote_err = 1'b1;
        end else begin
            vote_fail = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            add_a      <= '0;
            add_b      <= '0;
            r1         <= '0;
            r2         <= '0;
            settle_cnt <= '0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_err    <= 1'b0;
            out_fail   <= 1'b0;
            err_cnt    <= '0;
            fail_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a       <= in_a;
                        op_b       <= in_b;
                        add_a      <= in_a;
                        add_b      <= in_b;
                        settle_cnt <= '0;
                        state      <= P1;
                    end
                end
                P1: begin
                    if (pass_end) begin
                        r1         <= add_o;
                        settle_cnt <= '0;
                        add_a      <= SWAP_P2 ? op_b : op_a;
                        add_b      <= SWAP_P2 ? op_a : op_b;
                        state      <= P2;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                P2: begin
                    if (pass_end) begin
                        r2         <= add_o;
                        settle_cnt <= '0;
                        if (add_o == r1) begin
                            out_sum   <= r1;
                            out_err   <= 1'b0;
                            out_fail  <= 1'b0;
                            out_valid <= 1'b1;
                            add_a     <= '0;
                            add_b     <= '0;
                            state     <= DONE;
                        end else begin
                            add_a <= op_a;
                            add_b <= op_b;
                            state <= P3;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                P3: begin
                    if (pass_end) begin
                        settle_cnt <= '0;
                        out_sum    <= vote_sum;
                        out_err    <= vote_err;
                        out_fail   <= vote_fail;
                        out_valid  <= 1'b1;
                        add_a      <= '0;
                        add_b      <= '0;
                        state      <= DONE;
                        if (vote_err && (err_cnt != CNT_MAX))
                            err_cnt <= err_cnt + 1'b1;
                        if (vote_fail && (fail_cnt != CNT_MAX))
                            fail_cnt <= fail_cnt + 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        out_fail  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/addr8u_tr_voter.md
Name: addr8u_tr_voter

Overview:
- Time-redundant execution wrapper that sits directly upstream and downstream of an 8-bit unsigned adder instance.
- Accepts an operand pair over a valid/ready handshake and drives the adder operands over two passes: A,B and then the swapped B,A.
- Samples the adder's 9-bit sum after each pass. On a mismatch it runs a third A,B pass and majority-votes the three results.
- Delivers a voted sum plus error/failure flags, so transient faults inside the adder are masked at system level.

Parameters:
- CNT_W, 16, width of the saturating error and failure event counters.
- SETTLE, 0, extra wait cycles per pass before add_o is sampled (0..15), covering slow adder netlists.
- SWAP_P2, 1, when 1 pass 2 drives swapped operands (B,A); when 0 pass 2 repeats A,B.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  8  operand A, unsigned.
- in_b  in  8  operand B, unsigned.
- add_a  out  8  operand driven to the external adder's A[7:0].
- add_b  out  8  operand driven to the external adder's B[7:0].
- add_o  in  9  sum returned by the external adder, O[8:0]; combinational from add_a/add_b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  9  voted sum.
- out_err  out  1  mismatch detected and corrected by vote.
- out_fail  out  1  all three passes disagree; out_sum not trustworthy.
- err_cnt  out  CNT_W  saturating count of results with out_err=1.
- fail_cnt  out  CNT_W  saturating count of results with out_fail=1.

Behaviour:
- States: IDLE, P1, P2, P3, DONE. rst is asynchronous and forces IDLE.
- Reset values: add_a, add_b, out_sum, r1..r3 = 0; out_valid, out_err, out_fail = 0; err_cnt, fail_cnt = 0. in_ready = 1 in reset and whenever in IDLE.
- in_ready is 1 only in IDLE. An operand pair is accepted on a rising edge with in_valid && in_ready. in_a and in_b are registered, and the state moves to P1.
- add_a/add_b are registered outputs:
  - P1 and P3 drive A,B.
  - P2 drives B,A when SWAP_P2=1, otherwise A,B.
  - IDLE and DONE drive 0, which also reduces switching.
- Each pass lasts 1+SETTLE cycles, timed by a 4-bit settle counter. add_o is captured on the last edge of the pass into r1, r2 or r3.
- End of P2:
  - r1==r2: go to DONE with out_sum=r1, err=0, fail=0.
  - Otherwise: go to P3.
- End of P3:
  - r3==r1: out_sum=r1, err=1.
  - Else r3==r2: out_sum=r2, err=1.
  - Else: out_sum=r1, fail=1, err=0.
  - In all cases go to DONE.
- Latency from the accepting edge to out_valid=1:
  - No mismatch: 2*(1+SETTLE) edges.
  - Mismatch: 3*(1+SETTLE) edges.
- DONE:
  - out_valid=1; out_sum, out_err and out_fail are held stable until out_valid && out_ready on an edge.
  - That edge returns the state to IDLE and clears out_valid, out_err and out_fail. out_sum holds its last value.
  - No new operand is accepted on the same edge; the next acceptance is earliest one edge later.
- err_cnt and fail_cnt increment on the edge that enters DONE with the corresponding flag set. They saturate at 2^CNT_W-1, with no wrap.
- Arithmetic: out_sum is the full 9-bit sum. The carry is O[8]; there is no truncation or overflow.
- Simultaneous events: in_valid asserted outside IDLE is ignored, and the operand must be held by the producer.
- Reset mid-operation:
  - The operation is aborted with no out_valid pulse.
  - The counters clear.
  - in_ready is 1 on the first edge after rst deasserts.

Test Plan:
- Ideal adder model, SETTLE=0: in_a=200, in_b=100 -> add_a=200/add_b=100, then add_a=100/add_b=200; out_valid=1 two edges after acceptance; out_sum=0x12C, out_err=0, out_fail=0, err_cnt=0.
- Transient fault, adder model flips O[3] during P1 only; 0x0F+0x01 -> P3 executed; out_sum=0x010, out_err=1, err_cnt=1, latency 3 edges.
- Three-way disagreement, model returns 0x001, 0x002, 0x003 in passes 1-3 -> out_fail=1, out_err=0, out_sum=0x001, fail_cnt=1.
- Backpressure and SETTLE=2: 255+255 with out_ready held low 5 cycles -> out_valid held; out_sum=0x1FE stable; in_ready=0 throughout; completes the edge out_ready rises; out_valid first seen 6 edges after acceptance.
- Reset mid-P2: assert rst -> add_a=add_b=0, out_valid never pulses, in_ready=1, counters=0; the next transaction 1+1 returns 0x002.
- CNT_W=2, five consecutive single-pass-transient operations -> err_cnt sequence 1,2,3,3,3 (saturates, no wrap).
